// File: rtl/fp16_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fp16_pkg
//  Purpose  : Shared binary16 constants, flag indices and divider state type
//  Revision : 1.0 - initial release
// ============================================================================
package fp16_pkg;

  localparam int EXP_W   = 5;
  localparam int FRAC_W  = 10;
  localparam int BIAS    = 15;
  localparam int EXP_MAX = 31;
  localparam int QBITS   = 13;

  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [15:0] POS_INF = 16'h7C00;

  // Bit positions inside the 5-bit exception flag vector
  localparam int FLG_INV = 4;
  localparam int FLG_DZ  = 3;
  localparam int FLG_OF  = 2;
  localparam int FLG_UF  = 1;
  localparam int FLG_NX  = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    ROUND  = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fp16_classify.sv
`default_nettype none
// ============================================================================
//  Module   : fp16_classify
//  Purpose  : Combinational binary16 operand classifier (subnormals as zero)
//  Revision : 1.0 - initial release
// ============================================================================
module fp16_classify
  import fp16_pkg::*;
(
  input  logic [15:0]       i_x,
  output logic              o_is_zero,
  output logic              o_is_inf,
  output logic              o_is_nan,
  output logic              o_sign,
  output logic [EXP_W-1:0]  o_exp,
  output logic [FRAC_W:0]   o_sig
);

  logic [EXP_W-1:0]  w_exp;
  logic [FRAC_W-1:0] w_frac;
  logic              w_exp_min;
  logic              w_exp_top;

  assign w_exp     = i_x[14:10];
  assign w_frac    = i_x[9:0];
  assign w_exp_min = (w_exp == '0);
  assign w_exp_top = (w_exp == '1);

  // Subnormal inputs are treated as zero, so exp==0 alone decides zero-ness
  assign o_is_zero = w_exp_min;
  assign o_is_inf  = w_exp_top && (w_frac == '0);
  assign o_is_nan  = w_exp_top && (w_frac != '0);
  assign o_sign    = i_x[15];
  assign o_exp     = w_exp;
  assign o_sig     = w_exp_min ? '0 : {1'b1, w_frac};

endmodule
`default_nettype wire

// File: rtl/fp16_divider.sv
`default_nettype none
// ============================================================================
//  Module   : fp16_divider
//  Purpose  : Iterative binary16 divider a/b, restoring division one quotient
//             bit per clock, round-to-nearest-even, flush-to-zero
//  Revision : 1.0 - initial release
// ============================================================================
module fp16_divider #(
  parameter logic [15:0] QNAN = 16'h7E00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic [4:0]  flags
);
  import fp16_pkg::*;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_cap;        // operands captured, classification pending
  logic [15:0]        r_a;
  logic [15:0]        r_b;
  logic [11:0]        r_rem;
  logic [10:0]        r_mb;
  logic [QBITS-1:0]   r_q;
  logic [3:0]         r_cnt;
  logic signed [7:0]  r_exp;
  logic [15:0]        r_result;
  logic [4:0]         r_flags;

  logic               w_zero_a, w_inf_a, w_nan_a, w_sign_a;
  logic               w_zero_b, w_inf_b, w_nan_b, w_sign_b;
  logic [EXP_W-1:0]   w_exp_a, w_exp_b;
  logic [FRAC_W:0]    w_sig_a, w_sig_b;
  logic               w_sign;
  logic               w_special;
  logic [15:0]        w_spec_res;
  logic [4:0]         w_spec_flags;
  logic signed [7:0]  w_exp_init;
  logic               w_ge;
  logic [11:0]        w_diff;
  logic [10:0]        w_mant;
  logic               w_g, w_s;
  logic signed [7:0]  w_e, w_e_rnd;
  logic [11:0]        w_mant_rnd;
  logic [9:0]         w_mant_fin;
  logic [15:0]        w_rnd_res;
  logic [4:0]         w_rnd_flags;

  fp16_classify u_cls_a (
    .i_x       (r_a),
    .o_is_zero (w_zero_a),
    .o_is_inf  (w_inf_a),
    .o_is_nan  (w_nan_a),
    .o_sign    (w_sign_a),
    .o_exp     (w_exp_a),
    .o_sig     (w_sig_a)
  );

  fp16_classify u_cls_b (
    .i_x       (r_b),
    .o_is_zero (w_zero_b),
    .o_is_inf  (w_inf_b),
    .o_is_nan  (w_nan_b),
    .o_sign    (w_sign_b),
    .o_exp     (w_exp_b),
    .o_sig     (w_sig_b)
  );

  assign w_sign     = w_sign_a ^ w_sign_b;
  assign w_special  = w_zero_a | w_inf_a | w_nan_a | w_zero_b | w_inf_b | w_nan_b;
  assign w_exp_init = 8'({3'b000, w_exp_a}) - 8'({3'b000, w_exp_b}) + 8'(BIAS);
  assign w_ge       = (r_rem >= {1'b0, r_mb});
  assign w_diff     = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;
  assign result     = r_result;
  assign flags      = r_flags;

  // Special-operand result; priority puts NaN and invalid forms ahead of inf/zero
  always_comb begin
    w_spec_res   = {w_sign, 15'd0};
    w_spec_flags = '0;
    if (w_nan_a || w_nan_b) begin
      w_spec_res            = QNAN;
      w_spec_flags[FLG_INV] = 1'b1;
    end else if ((w_zero_a && w_zero_b) || (w_inf_a && w_inf_b)) begin
      w_spec_res            = QNAN;
      w_spec_flags[FLG_INV] = 1'b1;
    end else if (w_inf_a) begin
      w_spec_res = {w_sign, POS_INF[14:0]};
    end else if (w_zero_b) begin
      w_spec_res           = {w_sign, POS_INF[14:0]};
      w_spec_flags[FLG_DZ] = 1'b1;
    end
  end

  // Normalise the quotient, round to nearest even, then range-check the exponent
  always_comb begin
    w_e = r_exp;
    if (r_q[QBITS-1]) begin
      w_mant = r_q[12:2];
      w_g    = r_q[1];
      w_s    = r_q[0] | (r_rem != '0);
    end else begin
      w_mant = r_q[11:1];
      w_g    = r_q[0];
      w_s    = (r_rem != '0);
      w_e    = r_exp - 8'sd1;
    end
    w_mant_rnd = {1'b0, w_mant} + {11'd0, (w_g & (w_s | w_mant[0]))};
    w_e_rnd    = w_e;
    w_mant_fin = w_mant_rnd[9:0];
    if (w_mant_rnd == 12'h800) begin
      w_mant_fin = 10'd0;
      w_e_rnd    = w_e + 8'sd1;
    end
    w_rnd_flags = '0;
    if (w_e_rnd >= $signed(8'(EXP_MAX))) begin
      w_rnd_res           = {w_sign, POS_INF[14:0]};
      w_rnd_flags[FLG_OF] = 1'b1;
      w_rnd_flags[FLG_NX] = 1'b1;
    end else if (w_e_rnd <= 8'sd0) begin
      w_rnd_res           = {w_sign, 15'd0};
      w_rnd_flags[FLG_UF] = 1'b1;
      w_rnd_flags[FLG_NX] = 1'b1;
    end else begin
      w_rnd_res           = {w_sign, w_e_rnd[4:0], w_mant_fin};
      w_rnd_flags[FLG_NX] = w_g | w_s;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = !r_cap;
        if (r_cap) w_state_nxt = w_special ? DONE : DIVIDE;
      end
      DIVIDE: if (r_cnt == 4'(QBITS - 1)) w_state_nxt = ROUND;
      ROUND:  w_state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture, restoring-division steps and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cap    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_mb     <= '0;
      r_q      <= '0;
      r_cnt    <= '0;
      r_exp    <= '0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cap <= 1'b0;
          if (r_cap) begin
            if (w_special) begin
              r_result <= w_spec_res;
              r_flags  <= w_spec_flags;
            end else begin
              r_rem <= {1'b0, w_sig_a};
              r_mb  <= w_sig_b;
              r_q   <= '0;
              r_cnt <= '0;
              r_exp <= w_exp_init;
            end
          end else if (in_valid) begin
            r_a   <= a;
            r_b   <= b;
            r_cap <= 1'b1;
          end
        end
        DIVIDE: begin
          r_rem <= {w_diff[10:0], 1'b0};
          r_q   <= {r_q[QBITS-2:0], w_ge};
          r_cnt <= r_cnt + 4'd1;
        end
        ROUND: begin
          r_result <= w_rnd_res;
          r_flags  <= w_rnd_flags;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp16_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp16_divider
//  Purpose  : Self-checking bench for fp16_divider (queue-based scoreboard)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fp16_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [4:0]  flags;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [15:0] res;
    logic [4:0]  flg;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  fp16_divider dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  // Issue one operation, wait for the result and compare against the scoreboard.
  // With hold=1 the result is left pending in DONE for the caller.
  task automatic issue(input logic [15:0] ia, input logic [15:0] ib,
                       input logic [15:0] eres, input logic [4:0] eflg,
                       input int elat, input bit hold);
    exp_t e;
    exp_t got_e;
    int   lat;
    @(negedge clk);
    check_val("in_ready_idle", 32'(in_ready), 32'd1);
    a         = ia;
    b         = ib;
    in_valid  = 1'b1;
    out_ready = !hold;
    e.res = eres;
    e.flg = eflg;
    e.lat = elat;
    sb_q.push_back(e);
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    in_valid = 1'b0;
    a        = 16'($urandom);
    b        = 16'($urandom);
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    got_e = sb_q.pop_front();
    check_val("out_valid", 32'(out_valid), 32'd1);
    check_val("latency", 32'(lat), 32'(got_e.lat));
    check_val("result", 32'(result), 32'(got_e.res));
    check_val("flags", 32'(flags), 32'(got_e.flg));
    if (!hold) @(posedge clk);
  endtask

  initial begin
    bit seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    #12;
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_result", 32'(result), 32'h0);
    check_val("rst_flags", 32'(flags), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    issue(16'h4400, 16'h4000, 16'h4000, 5'b00000, 15, 1'b0);
    issue(16'h3C00, 16'h4200, 16'h3555, 5'b00001, 15, 1'b0);
    issue(16'h3C00, 16'h0000, 16'h7C00, 5'b01000, 1, 1'b0);
    issue(16'h0000, 16'h0000, 16'h7E00, 5'b10000, 1, 1'b0);
    issue(16'hFC00, 16'h4000, 16'hFC00, 5'b00000, 1, 1'b0);
    issue(16'h7D00, 16'h3C00, 16'h7E00, 5'b10000, 1, 1'b0);
    issue(16'h7BFF, 16'h3800, 16'h7C00, 5'b00101, 15, 1'b0);
    issue(16'h0400, 16'h4000, 16'h0000, 5'b00011, 15, 1'b0);
    issue(16'h3C00, 16'h3BFF, 16'h3C01, 5'b00001, 15, 1'b0);
    issue(16'h4000, 16'h4200, 16'h3955, 5'b00001, 15, 1'b0);
    issue(16'hC400, 16'h4000, 16'hC000, 5'b00000, 15, 1'b0);
    issue(16'h3C00, 16'h7C00, 16'h0000, 5'b00000, 1, 1'b0);
    issue(16'h4000, 16'h8000, 16'hFC00, 5'b01000, 1, 1'b0);
    issue(16'h7C00, 16'h7C00, 16'h7E00, 5'b10000, 1, 1'b0);
    issue(16'h0001, 16'h3C00, 16'h0000, 5'b00000, 1, 1'b0);
    issue(16'h8000, 16'h4000, 16'h8000, 5'b00000, 1, 1'b0);

    // Backpressure: result must hold while out_ready is low, new requests ignored
    issue(16'h4400, 16'h4000, 16'h4000, 5'b00000, 15, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a        = 16'h3C00;
      b        = 16'h0000;
      @(posedge clk);
      @(negedge clk);
      check_val("bp_result", 32'(result), 32'h4000);
      check_val("bp_flags", 32'(flags), 32'h0);
      check_val("bp_in_ready", 32'(in_ready), 32'd0);
      check_val("bp_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    issue(16'h3C00, 16'h4200, 16'h3555, 5'b00001, 15, 1'b0);

    // Asynchronous reset in the middle of the divide loop
    @(negedge clk);
    a        = 16'h4400;
    b        = 16'h4000;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_out_valid", 32'(out_valid), 32'd0);
    check_val("arst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check_val("arst_no_result", 32'(seen), 32'd0);
    issue(16'h4400, 16'h4000, 16'h4000, 5'b00000, 15, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
